// File: rtl/rv_pkg.sv
// Shared RV32I/M decode definitions: opcodes, field constants, decoded-instruction
// struct and the decode helper used by the issue stage.
package rv_pkg;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);
  localparam int PC_W   = 8;
  localparam int XLEN   = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SRX  = 3'b101;
  localparam logic [2:0] F3_ZERO = 3'b000;
  localparam logic [6:0] F7_ZERO = 7'b0000000;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [11:0]       imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [PC_W-1:0]   pc;
  } decoded_t;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  // Illegal opcodes decode to an all-zero ALU view so the ALU produces 0.
  function automatic decoded_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    decoded_t d;
    d.opcode = instr[6:0];
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct7 = instr[31:25];
    d.imm    = '0;
    d.pc     = pc;
    case (instr[6:0])
      OP_R: d.imm = '0;
      OP_I: begin
        if (d.funct3 == F3_SLL || d.funct3 == F3_SRX) begin
          d.imm = {7'b0, instr[24:20]};
        end else begin
          d.imm    = instr[31:20];
          d.funct7 = F7_ZERO;
        end
      end
      OP_LUI, OP_AUIPC: begin
        d.imm    = instr[23:12];
        d.funct3 = F3_ZERO;
        d.funct7 = F7_ZERO;
      end
      default: begin
        d.opcode = '0;
        d.funct7 = '0;
        d.funct3 = '0;
        d.imm    = '0;
      end
    endcase
    return d;
  endfunction
endpackage

// File: rtl/regfile.sv
// Integer register file: three combinational read ports, one synchronous write
// port, asynchronous clear, x0 hardwired to zero.
module regfile
  import rv_pkg::*;
#(
  parameter int N = NREGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [$clog2(N)-1:0] rs1_addr,
  output logic [XLEN-1:0]      rs1_data,
  input  logic [$clog2(N)-1:0] rs2_addr,
  output logic [XLEN-1:0]      rs2_data,
  input  logic [$clog2(N)-1:0] dbg_addr,
  output logic [XLEN-1:0]      dbg_data
);
  logic [XLEN-1:0] regs [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/decode_issue.sv
// ALU front end: decodes RV32I/M words into a registered E stage with operand
// forwarding, and retires the ALU result through a W stage into the register file.
module decode_issue
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              stall,
  output logic [6:0]        alu_opcode,
  output logic [6:0]        alu_funct7,
  output logic [2:0]        alu_funct3,
  output logic [11:0]       alu_imm,
  output logic [PC_W-1:0]   alu_pc,
  output logic [XLEN-1:0]   alu_rs1_val,
  output logic [XLEN-1:0]   alu_rs2_val,
  input  logic [XLEN-1:0]   alu_rd_val,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);
  decoded_t          dec;
  logic              dec_legal;
  logic              accept;
  logic [XLEN-1:0]   rf_rs1, rf_rs2, fwd_rs1, fwd_rs2;
  logic              e_valid, e_legal, e_wr;
  logic [REG_AW-1:0] e_rd;
  logic              w_wr, rf_we;
  logic [REG_AW-1:0] w_rd;
  logic [XLEN-1:0]   w_data;

  // Handshake: in_ready depends only on stall; an instruction transfers on any
  // rising edge where in_valid && in_ready, and is then visible in E.
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready;
  assign dec       = decode(in_instr, in_pc);
  assign dec_legal = is_legal(in_instr[6:0]);
  assign e_wr      = e_valid && e_legal && (e_rd != '0);
  assign rf_we     = w_wr && !stall;

  function automatic logic [XLEN-1:0] fwd(
    input logic [REG_AW-1:0] rs,
    input logic              e_hit_en,
    input logic [REG_AW-1:0] e_rd_i,
    input logic [XLEN-1:0]   e_val,
    input logic              w_hit_en,
    input logic [REG_AW-1:0] w_rd_i,
    input logic [XLEN-1:0]   w_val,
    input logic [XLEN-1:0]   rf_val
  );
    if (rs == '0) return '0;
    else if (e_hit_en && e_rd_i == rs) return e_val;
    else if (w_hit_en && w_rd_i == rs) return w_val;
    else return rf_val;
  endfunction

  assign fwd_rs1 = fwd(dec.rs1, e_wr, e_rd, alu_rd_val, w_wr, w_rd, w_data, rf_rs1);
  assign fwd_rs2 = fwd(dec.rs2, e_wr, e_rd, alu_rd_val, w_wr, w_rd, w_data, rf_rs2);

  regfile #(.N(NREGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (w_rd),
    .wdata    (w_data),
    .rs1_addr (dec.rs1),
    .rs1_data (rf_rs1),
    .rs2_addr (dec.rs2),
    .rs2_data (rf_rs2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid     <= 1'b0;
      e_legal     <= 1'b0;
      e_rd        <= '0;
      alu_opcode  <= '0;
      alu_funct7  <= '0;
      alu_funct3  <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rs1_val <= '0;
      alu_rs2_val <= '0;
      illegal     <= 1'b0;
      w_wr        <= 1'b0;
      w_rd        <= '0;
      w_data      <= '0;
    end else if (stall) begin
      illegal <= 1'b0;
    end else begin
      illegal <= accept && !dec_legal;
      w_wr    <= e_wr;
      w_rd    <= e_rd;
      w_data  <= alu_rd_val;
      if (accept) begin
        e_valid     <= 1'b1;
        e_legal     <= dec_legal;
        e_rd        <= dec.rd;
        alu_opcode  <= dec.opcode;
        alu_funct7  <= dec.funct7;
        alu_funct3  <= dec.funct3;
        alu_imm     <= dec.imm;
        alu_pc      <= dec.pc;
        alu_rs1_val <= fwd_rs1;
        alu_rs2_val <= fwd_rs2;
      end else begin
        e_valid     <= 1'b0;
        e_legal     <= 1'b0;
        e_rd        <= '0;
        alu_opcode  <= '0;
        alu_funct7  <= '0;
        alu_funct3  <= '0;
        alu_imm     <= '0;
        alu_pc      <= '0;
        alu_rs1_val <= '0;
        alu_rs2_val <= '0;
      end
    end
  end
endmodule

// File: tb/tb_decode_issue.sv
// Randomized bench for decode_issue: a behavioural ALU closes the loop and an
// in-order architectural register model predicts operands and final state.
module tb_decode_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_pc;
  logic        stall;
  logic [6:0]  alu_opcode, alu_funct7;
  logic [2:0]  alu_funct3;
  logic [11:0] alu_imm;
  logic [7:0]  alu_pc;
  logic [31:0] alu_rs1_val, alu_rs2_val, alu_rd_val;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_regs [32];
  logic [31:0] exp_q [$];
  logic [7:0]  pc_ctr;

  logic [6:0]  e_op, e_f7;
  logic [2:0]  e_f3;
  logic [11:0] e_imm;
  logic [7:0]  e_pc;
  logic [31:0] e_a, e_b;
  logic        e_full;
  logic        exp_ill;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .stall       (stall),
    .alu_opcode  (alu_opcode),
    .alu_funct7  (alu_funct7),
    .alu_funct3  (alu_funct3),
    .alu_imm     (alu_imm),
    .alu_pc      (alu_pc),
    .alu_rs1_val (alu_rs1_val),
    .alu_rs2_val (alu_rs2_val),
    .alu_rd_val  (alu_rd_val),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  function automatic logic [31:0] alu_fn(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [11:0] imm,
                                         input logic [7:0] pc, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] bi;
    bi = (op == 7'h33) ? b : {{20{imm[11]}}, imm};
    case (op)
      7'h33, 7'h13: begin
        if (op == 7'h33 && f7 == 7'h01) return a * b;
        case (f3)
          3'd0: return (op == 7'h33 && f7 == 7'h20) ? a - bi : a + bi;
          3'd1: return a << bi[4:0];
          3'd2: return ($signed(a) < $signed(bi)) ? 32'd1 : 32'd0;
          3'd3: return (a < bi) ? 32'd1 : 32'd0;
          3'd4: return a ^ bi;
          3'd5: return f7[5] ? 32'($signed(a) >>> bi[4:0]) : a >> bi[4:0];
          3'd6: return a | bi;
          default: return a & bi;
        endcase
      end
      7'h37: return {8'b0, imm, 12'b0};
      7'h17: return {8'b0, imm, 12'b0} + {24'b0, pc};
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_rd_val = alu_fn(alu_opcode, alu_funct3, alu_funct7, alu_imm, alu_pc,
                                  alu_rs1_val, alu_rs2_val);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    e_op = '0; e_f7 = '0; e_f3 = '0; e_imm = '0; e_pc = '0;
    e_a = '0; e_b = '0; e_full = 1'b0; exp_ill = 1'b0;
    pc_ctr = 8'd0;
  endtask

  // Sequential ISA view: operands come from architectural state, result retires at once.
  task automatic issue_model(input logic [31:0] instr, input logic [7:0] pc);
    logic [4:0] rs1, rs2, rd;
    rs1 = instr[19:15]; rs2 = instr[24:20]; rd = instr[11:7];
    e_op = instr[6:0]; e_f3 = instr[14:12]; e_f7 = instr[31:25];
    e_imm = '0; e_pc = pc; e_full = 1'b1; exp_ill = 1'b0;
    case (instr[6:0])
      7'h33: ;
      7'h13: begin
        if (e_f3 == 3'd1 || e_f3 == 3'd5) e_imm = {7'b0, instr[24:20]};
        else begin e_imm = instr[31:20]; e_f7 = '0; end
      end
      7'h37, 7'h17: begin e_imm = instr[23:12]; e_f3 = '0; e_f7 = '0; end
      default: begin e_op = '0; e_full = 1'b0; exp_ill = 1'b1; end
    endcase
    e_a = (rs1 == 0) ? 32'd0 : model_regs[rs1];
    e_b = (rs2 == 0) ? 32'd0 : model_regs[rs2];
    if (e_full && rd != 0) model_regs[rd] = alu_fn(e_op, e_f3, e_f7, e_imm, e_pc, e_a, e_b);
  endtask

  task automatic step(input logic v, input logic [31:0] instr, input logic st);
    @(negedge clk);
    in_valid = v; in_instr = instr; in_pc = pc_ctr; stall = st;
    #1;
    check("in_ready", {31'b0, in_ready}, {31'b0, !st});
    exp_ill = 1'b0;
    if (v && !st) begin
      issue_model(instr, pc_ctr);
      pc_ctr = pc_ctr + 8'd4;
    end else if (!st) begin
      e_op = '0; e_full = 1'b0;
    end
    @(posedge clk);
    #1;
    check("opcode", 32'(alu_opcode), 32'(e_op));
    check("illegal", 32'(illegal), 32'(exp_ill));
    if (e_full) begin
      check("funct7", 32'(alu_funct7), 32'(e_f7));
      check("funct3", 32'(alu_funct3), 32'(e_f3));
      check("imm", 32'(alu_imm), 32'(e_imm));
      check("pc", 32'(alu_pc), 32'(e_pc));
      check("rs1_val", alu_rs1_val, e_a);
      check("rs2_val", alu_rs2_val, e_b);
    end
    in_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0);
  endtask

  task automatic dbg_check_all();
    idle(2);
    for (int i = 0; i < 32; i++) exp_q.push_back(model_regs[i]);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 32'd0, 1'b0);
      dbg_addr = 5'(i);
      #1;
      check("dbg_reg", dbg_data, exp_q.pop_front());
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    if (k <= 3) begin
      r[6:0] = 7'h33;
      case ($urandom_range(0, 2))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        default: r[31:25] = 7'h01;
      endcase
    end else if (k <= 6) r[6:0] = 7'h13;
    else if (k == 7) r[6:0] = 7'h37;
    else if (k == 8) r[6:0] = 7'h17;
    else r[6:0] = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h03;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; in_instr = '0; in_pc = '0; dbg_addr = '0;
    reset_model();
    #12;
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_funct7", 32'(alu_funct7), 32'd0);
    check("rst_funct3", 32'(alu_funct3), 32'd0);
    check("rst_imm", 32'(alu_imm), 32'd0);
    check("rst_pc", 32'(alu_pc), 32'd0);
    check("rst_rs1", alu_rs1_val, 32'd0);
    check("rst_rs2", alu_rs2_val, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check("rst_dbg", dbg_data, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);

    // ADDI x1,x0,5 ; ADD x2,x1,x1 back to back
    step(1'b1, enc_i(12'd5, 5'd0, 3'd0, 5'd1), 1'b0);
    step(1'b1, enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2), 1'b0);
    check("fwd_rs1", alu_rs1_val, 32'd5);
    check("fwd_rs2", alu_rs2_val, 32'd5);
    idle(2);
    dbg_addr = 5'd2;
    #1;
    check("x2_after", dbg_data, 32'd10);

    // SRAI x3,x1,2
    step(1'b1, 32'h4020D193, 1'b0);
    check("srai_imm", 32'(alu_imm), 32'd2);
    check("srai_f7", 32'(alu_funct7), 32'h20);
    check("srai_f3", 32'(alu_funct3), 32'd5);

    // ADDI x0,x0,7 then a read of x0
    step(1'b1, enc_i(12'd7, 5'd0, 3'd0, 5'd0), 1'b0);
    step(1'b1, enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd5), 1'b0);
    check("x0_rs1", alu_rs1_val, 32'd0);
    idle(2);
    dbg_addr = 5'd0;
    #1;
    check("x0_dbg", dbg_data, 32'd0);

    // Unsupported opcode 0x7F targeting x7
    step(1'b1, 32'h000003FF, 1'b0);
    check("ill_pulse", 32'(illegal), 32'd1);
    check("ill_opcode", 32'(alu_opcode), 32'd0);
    step(1'b0, 32'd0, 1'b0);
    check("ill_drop", 32'(illegal), 32'd0);
    dbg_check_all();

    // Stall while W holds ADDI x4,x0,9
    step(1'b1, enc_i(12'd9, 5'd0, 3'd0, 5'd4), 1'b0);
    step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 1'b1);
      dbg_addr = 5'd4;
      #1;
      check("stall_x4", dbg_data, 32'd0);
    end
    step(1'b0, 32'd0, 1'b0);
    dbg_addr = 5'd4;
    #1;
    check("release_x4", dbg_data, 32'd9);

    // Asynchronous reset with writes in flight
    step(1'b1, enc_i(12'd11, 5'd0, 3'd0, 5'd6), 1'b0);
    step(1'b1, enc_i(12'd3, 5'd0, 3'd0, 5'd7), 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_opcode", 32'(alu_opcode), 32'd0);
    check("async_rs1", alu_rs1_val, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    dbg_check_all();

    for (int blk = 0; blk < 5; blk++) begin
      for (int n = 0; n < 60; n++) begin
        step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 4) == 0));
      end
      dbg_check_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
